gaussian_smoother: RTL
======================

# gaussian_smoother

Streaming 3x3 Gaussian smoothing stage directly upstream of the all-directions edge detector in the Canny pipeline. It accepts one 8-bit greyscale pixel per enabled cycle in raster order. It holds two image rows in line buffers and emits one smoothed pixel per complete 3x3 window. Its output stream is the data the up/down and left/right gradient stages consume.

## Interface
- IMG_WIDTH, 64, pixels per row (>= 3)
- IMG_HEIGHT, 64, rows per frame (>= 3)
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all control state
- enb  in  1  input pixel valid; pixel consumed on every rising edge with enb=1 while not DONE
- pixelIn  in  8  unsigned greyscale input pixel
- pixelOut  out  8  smoothed pixel; reset 0; holds last value when outValid=0
- outValid  out  1  pixelOut valid this cycle; reset 0
- complete  out  1  level; high once the last output of the frame has been emitted; held until reset; reset 0

## Operation
- Kernel [1 2 1; 2 4 2; 1 2 1], weight sum 16.
- Sum is 12 bits unsigned (max 4080).
- Output = (sum + 8) >> 4, which rounds half up. The maximum result is 255, so no saturation is needed.
- Only interior windows are produced. Output frame is (IMG_WIDTH-2) x (IMG_HEIGHT-2) pixels in raster order, centres at rows 1..H-2 and cols 1..W-2.
- Counters col (0..W-1) and row (0..H-1) advance on each accepted pixel. col wraps to 0 and row increments at col=W-1.
- Two line buffers, each W x 8, hold rows r-1 and r-2.
  - Each buffer is read and written at address col in the same accepted cycle (read-before-write).
  - The write cascades: pixelIn goes to lb0 and the old lb0 value goes to lb1.
- A 3x3 window register shifts left by one column on every accepted pixel. The new right column is {lb1 out, lb0 out, pixelIn}.
- The window is complete after an accepted pixel with row>=2 and col>=2.
- FSM states:
  - FILL: row<2. Accept pixels, no windows. Go to RUN on the accepted pixel at col=W-1, row=1.
  - RUN: window complete on qualifying pixels. Go to DRAIN on the accepted pixel at row=H-1, col=W-1.
  - DRAIN: enb ignored. Go to DONE once the final outValid has been issued.
  - DONE: complete=1, enb ignored, no outputs. Leave only via reset.
- enb=0 cycles stall counters and window. The already-launched pipeline still completes.
- Reset mid-frame: counters, window-valid pipeline, outValid, complete and FSM (to FILL) clear in that cycle. Line buffer contents are not cleared, because FILL overwrites them before use.
- reset has priority over enb in the same cycle.

## Timing
- Latency is exactly 2 cycles from the accepting edge of the window-completing pixel to outValid.
  - Edge 0: window register loads.
  - Edge 1: sum register loads.
  - Edge 2: pixelOut and outValid register.
- Stages 1–2 advance every cycle regardless of enb.
- Throughput is one output per cycle in steady state.
- There are no outputs during the first two rows or the first two columns of each row.
- complete rises on the edge after the final outValid cycle.
- There is no back-pressure. Downstream must accept every outValid cycle.

## Structure
- Shared package canny_pkg:
  - PIX_W=8, SUM_W=12
  - kernel weight constants
  - smoother state enum (FILL, RUN, DRAIN, DONE)
- Sub-module line_buffer holds one W x 8 row. It is a synchronous-write RAM with combinational read-before-write at a shared address, instantiated twice.
- Top level contains the counters, FSM, window register, adder tree and output register.

## Test plan
All scenarios use IMG_WIDTH=IMG_HEIGHT=5, so 9 outputs per frame.
- Flat image, all 100, enb continuous: 9 outputs all 100. First outValid 2 cycles after accepting pixel (2,2). complete=1 the cycle after the 9th output.
- Impulse of 255 at (2,2), zeros elsewhere: outputs row-major are 16,32,16 / 32,64,32 / 16,32,16.
- All 255: every output 255, with no overflow in the 12-bit sum.
- Random enb gaps, 0–3 idle cycles between pixels: output values match the continuous run. Each outValid comes exactly 2 cycles after its qualifying accepted pixel.
- Extra pixels after the frame with enb held high: no further outValid, complete stays 1, pixelOut unchanged.
- Reset asserted after 12 pixels, then a full flat-50 frame: outValid and complete are 0 on the next edge. Exactly 9 outputs of 50 follow, with no stale data from the aborted frame.

Source files
------------

// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny pipeline stages.
// Holds pixel/sum widths, the Gaussian kernel weights and the smoother FSM states.
package canny_pkg;

    localparam int PIX_W      = 8;
    localparam int SUM_W      = 12;
    localparam int NORM_SHIFT = 4;

    localparam logic [SUM_W-1:0] K_CORNER = SUM_W'(1);
    localparam logic [SUM_W-1:0] K_EDGE   = SUM_W'(2);
    localparam logic [SUM_W-1:0] K_CENTRE = SUM_W'(4);
    // Half of the weight sum, so the shift rounds half up.
    localparam logic [SUM_W-1:0] ROUND    = SUM_W'(8);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } smoother_state_e;

    function automatic logic [SUM_W-1:0] kernel_weight(input int r, input int c);
        if (r == 1 && c == 1)      return K_CENTRE;
        else if (r == 1 || c == 1) return K_EDGE;
        else                       return K_CORNER;
    endfunction

endpackage

// File: rtl/gaussian_smoother_if.sv
// Pixel stream into the smoother and smoothed stream out of it.
interface gaussian_smoother_if;
    import canny_pkg::*;

    logic             enb;
    logic [PIX_W-1:0] pixelIn;
    logic [PIX_W-1:0] pixelOut;
    logic             outValid;
    logic             complete;

    modport master (output enb, pixelIn, input pixelOut, outValid, complete);
    modport slave  (input enb, pixelIn, output pixelOut, outValid, complete);

endinterface

// File: rtl/line_buffer.sv
// One image row of storage: synchronous write, combinational read at the same
// address, so a read in the writing cycle returns the previous row's pixel.
module line_buffer
    import canny_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    logic [PIX_W-1:0] mem [DEPTH];

    assign dout = mem[addr];

    // NOTE: storage arrays carry no reset; every entry is overwritten during FILL
    // before it is read, and a reset port would stop this mapping to RAM.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
    end

endmodule

// File: rtl/gaussian_smoother.sv
// Streaming 3x3 Gaussian smoother: two line buffers feed a shifting window,
// then a registered adder tree and a rounding output stage.
module gaussian_smoother
    import canny_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                clk,
    input  logic                reset,
    gaussian_smoother_if.slave  pix
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    smoother_state_e  state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             accept;
    logic             at_row_end;
    logic             win_done;
    logic [PIX_W-1:0] lb0_q;
    logic [PIX_W-1:0] lb1_q;
    logic [PIX_W-1:0] win [3][3];
    logic             win_valid;
    logic             sum_valid;
    logic [SUM_W-1:0] sum_d;
    logic [SUM_W-1:0] sum_q;
    logic [PIX_W-1:0] pixel_out;
    logic             out_valid;
    logic             done;

    assign accept     = pix.enb && (state == ST_FILL || state == ST_RUN);
    assign at_row_end = (col == COL_LAST);
    assign win_done   = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));

    // lb0 holds row r-1, lb1 holds row r-2; the write cascades lb0 into lb1.
    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
        .clk  (clk),
        .we   (accept),
        .addr (col),
        .din  (pix.pixelIn),
        .dout (lb0_q)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .clk  (clk),
        .we   (accept),
        .addr (col),
        .din  (lb0_q),
        .dout (lb1_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FILL;
            col   <= '0;
            row   <= '0;
            done  <= 1'b0;
        end else begin
            if (accept) begin
                if (at_row_end) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            case (state)
                ST_FILL:  if (accept && at_row_end && row == ROW_W'(1)) state <= ST_RUN;
                ST_RUN:   if (accept && at_row_end && row == ROW_LAST) state <= ST_DRAIN;
                ST_DRAIN: if (out_valid && !sum_valid && !win_valid) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE:  state <= ST_DONE;
                default:  state <= ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1_q;
            win[1][2] <= lb0_q;
            win[2][2] <= pix.pixelIn;
        end
        sum_q <= sum_d;
    end

    // NOTE: always_comb outputs get a default first so no path leaves them unassigned
    // and no latch is inferred.
    always_comb begin
        sum_d = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                sum_d = sum_d + SUM_W'(win[r][c]) * kernel_weight(r, c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid <= 1'b0;
            sum_valid <= 1'b0;
            out_valid <= 1'b0;
            pixel_out <= '0;
        end else begin
            win_valid <= win_done;
            sum_valid <= win_valid;
            out_valid <= sum_valid;
            if (sum_valid) pixel_out <= PIX_W'((sum_q + ROUND) >> NORM_SHIFT);
        end
    end

    assign pix.pixelOut = pixel_out;
    assign pix.outValid = out_valid;
    assign pix.complete = done;

endmodule
